// File: rtl/sdr_rx_pkg.sv
// Shared definitions for the 1-bit receive chain: the ±1 sample encoding and
// the CIC accumulator width rule.
package sdr_rx_pkg;

   localparam logic [1:0] PLUS_ONE  = 2'b01;
   localparam logic [1:0] MINUS_ONE = 2'b11;

   function automatic int cic_width(input int log2_decim, input int cic_order);
      return 2 + cic_order * log2_decim;
   endfunction

   // Multiplying two ±1 values coded as 1/0 is an XNOR: equal signs give +1.
   function automatic logic [1:0] mix(input logic a, input logic b);
      return (a ~^ b) ? PLUS_ONE : MINUS_ONE;
   endfunction

endpackage

// File: rtl/cic_decim_chan.sv
// One CIC decimator channel: N integrators at the sample rate, an N-stage comb
// chain stepped by the shared strobe delay line, and a truncating output register.
module cic_decim_chan
   import sdr_rx_pkg::*;
#(
   parameter int LOG2_DECIM = 6,
   parameter int CIC_ORDER  = 4,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             sample,
   input  logic [CIC_ORDER+1:0]   stb,
   output logic [OUT_WIDTH-1:0]   data
);

   localparam int W = cic_width(LOG2_DECIM, CIC_ORDER);

   logic [W-1:0] sample_ext;
   logic [W-1:0] integ    [CIC_ORDER];
   logic [W-1:0] comb_in;
   logic [W-1:0] comb_src [CIC_ORDER];
   logic [W-1:0] comb_dly [CIC_ORDER];
   logic [W-1:0] comb_q   [CIC_ORDER];
   logic [W-1:0] comb_last;

   assign sample_ext = {{(W-2){sample[1]}}, sample};
   assign comb_last  = comb_q[CIC_ORDER-1];

   // Integrators wrap modulo 2^W; the comb differences undo the wrap exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the accumulator arrays are reset explicitly; an X or stale value
         // in a free-running integrator would never wash out of the output.
         for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
      end else begin
         integ[0] <= integ[0] + sample_ext;
         for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
      end
   end

   always_comb begin
      // NOTE: every element is assigned on every pass so no latch can be inferred.
      comb_src[0] = comb_in;
      for (int k = 1; k < CIC_ORDER; k++) comb_src[k] = comb_q[k-1];
   end

   // stb[0] captures the last integrator, stb[k] steps comb stage k,
   // stb[N+1] loads the output word.
   always_ff @(posedge clk) begin
      if (rst) begin
         comb_in <= '0;
         for (int k = 0; k < CIC_ORDER; k++) begin
            comb_dly[k] <= '0;
            comb_q[k]   <= '0;
         end
         data <= '0;
      end else begin
         if (stb[0]) comb_in <= integ[CIC_ORDER-1];
         for (int k = 0; k < CIC_ORDER; k++) begin
            if (stb[k+1]) begin
               comb_q[k]   <= comb_src[k] - comb_dly[k];
               comb_dly[k] <= comb_src[k];
            end
         end
         if (stb[CIC_ORDER+1]) data <= comb_last[W-1 -: OUT_WIDTH];
      end
   end

   generate
      if (OUT_WIDTH < W) begin : g_trunc
         logic unused_lsbs;
         assign unused_lsbs = ^comb_last[W-OUT_WIDTH-1:0];
      end
   endgenerate

endmodule

// File: rtl/iq_mixer_cic.sv
// 1-bit RF x 1-bit LO quadrature mixer feeding two CIC decimators that share
// one decimation counter and strobe delay line.
module iq_mixer_cic
   import sdr_rx_pkg::*;
#(
   parameter int LOG2_DECIM = 6,
   parameter int CIC_ORDER  = 4,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rf_in,
   input  logic                 lo_cos,
   input  logic                 lo_sin,
   output logic [OUT_WIDTH-1:0] i_out,
   output logic [OUT_WIDTH-1:0] q_out,
   output logic                 out_valid
);

   localparam logic [LOG2_DECIM-1:0] CNT_ONE = LOG2_DECIM'(1);

   logic                    rf_q;
   logic                    cos_q;
   logic                    sin_q;
   logic [LOG2_DECIM-1:0]   cnt;
   logic                    dec_stb;
   logic [CIC_ORDER+1:1]    stb_dly;
   logic [CIC_ORDER+1:0]    stb_all;
   logic [1:0]              i_sample;
   logic [1:0]              q_sample;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge value of its neighbours.
         rf_q  <= 1'b0;
         cos_q <= 1'b0;
         sin_q <= 1'b0;
      end else begin
         rf_q  <= rf_in;
         cos_q <= lo_cos;
         sin_q <= lo_sin;
      end
   end

   assign i_sample = mix(rf_q, cos_q);
   assign q_sample = mix(rf_q, sin_q);

   // Counter wraps naturally at R-1 since R is a power of two.
   assign dec_stb = &cnt;
   assign stb_all = {stb_dly, dec_stb};

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         stb_dly   <= '0;
         out_valid <= 1'b0;
      end else begin
         cnt       <= cnt + CNT_ONE;
         stb_dly   <= {stb_dly[CIC_ORDER:1], dec_stb};
         out_valid <= stb_dly[CIC_ORDER+1];
      end
   end

   cic_decim_chan #(
      .LOG2_DECIM (LOG2_DECIM),
      .CIC_ORDER  (CIC_ORDER),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_chan_i (
      .clk    (clk),
      .rst    (rst),
      .sample (i_sample),
      .stb    (stb_all),
      .data   (i_out)
   );

   cic_decim_chan #(
      .LOG2_DECIM (LOG2_DECIM),
      .CIC_ORDER  (CIC_ORDER),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_chan_q (
      .clk    (clk),
      .rst    (rst),
      .sample (q_sample),
      .stb    (stb_all),
      .data   (q_out)
   );

endmodule
